// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead adder/subtractor with ALU status flags
module cla_addsub_pipe #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int SW = 4 * GROUPS_PER_STAGE;
    localparam int L  = WIDTH / SW;

    logic             adv;
    logic [WIDTH-1:0] b_x;
    logic             c0;
    logic             msbc_q;

    // returns {carry_out, sum[3:0]} of one 4-bit lookahead group
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign b_x      = op[0] ? ~b : b;
    assign c0       = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : cin;

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]    ra;
        logic [RW-1:0]    rb;
        logic             ci;
        logic             vi;
        logic [SW-1:0]    ps;
        logic             c_d;
        logic [LO+SW-1:0] s_d;
        logic [LO+SW-1:0] s_q;
        logic             v_q;
        logic             c_q;

        // ra/rb hold only the operand bits not yet consumed, shifted down to bit 0
        if (k == 0) begin : g_head
            assign ra  = a;
            assign rb  = b_x;
            assign ci  = c0;
            assign vi  = in_valid;
            assign s_d = ps;
        end else begin : g_body
            assign ra  = g_stage[k-1].g_fwd.a_q;
            assign rb  = g_stage[k-1].g_fwd.b_q;
            assign ci  = g_stage[k-1].c_q;
            assign vi  = g_stage[k-1].v_q;
            assign s_d = {ps, g_stage[k-1].s_q};
        end

        always_comb begin : eval
            logic       c;
            logic [4:0] r;
            c  = ci;
            r  = '0;
            ps = '0;
            for (int g = 0; g < GROUPS_PER_STAGE; g++) begin
                r             = cla4(ra[4*g +: 4], rb[4*g +: 4], c);
                ps[4*g +: 4]  = r[3:0];
                c             = r[4];
            end
            c_d = c;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= vi;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        if (k < L - 1) begin : g_fwd
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] b_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= ra[RW-1:SW];
                    b_q <= rb[RW-1:SW];
                end
            end
        end else begin : g_tail
            // carry into the MSB recovered from its sum bit: s = a ^ b ^ c_in
            always_ff @(posedge clk) begin
                if (reset) begin
                    msbc_q <= 1'b0;
                end else if (adv) begin
                    msbc_q <= ps[SW-1] ^ ra[SW-1] ^ rb[SW-1];
                end
            end
        end
    end

    assign out_valid = g_stage[L-1].v_q;
    assign sum       = g_stage[L-1].s_q;
    assign cout      = g_stage[L-1].c_q;
    assign ovf       = msbc_q ^ cout;
    assign zero      = ~|sum;
    assign neg       = sum[WIDTH-1];

endmodule

// File: doc/cla_addsub_pipe.md
# cla_addsub_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the CPU datapath: the next generation of the team's 4-bit CLA adder. It generalises operand width, supports add, subtract, add-with-carry and subtract-with-borrow, and produces ALU status flags. A valid/ready handshake with back-pressure lets the ALU stall it. Internally it chains 4-bit CLA groups, with a pipeline register after every GROUPS_PER_STAGE groups.

## Interface
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and at least 4.
- GROUPS_PER_STAGE, 1: 4-bit CLA groups evaluated per pipeline stage. WIDTH/4 must be divisible by it.
- Derived L = WIDTH / (4*GROUPS_PER_STAGE): number of pipeline stages, which equals the latency.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op present.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- cin  in  1  carry flag input; used only by ADC/SBB.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For SUB/SBB, 1 means no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

## Operation
- Operand transform at input:
  - B' = b for ADD/ADC; B' = ~b for SUB/SBB.
  - c0 = 0 for ADD, 1 for SUB, cin for ADC, cin for SBB. SBB takes cin=1 to mean no borrow pending, ARM-style.
- Per 4-bit group: G = A&B', P = A^B', lookahead carries, S = P ^ {C[2:0],c_in_group}. Group carry-out feeds the next group.
- Stage k (0..L-1) evaluates groups k*GPS .. (k+1)*GPS-1:
  - It uses the carry registered by stage k-1.
  - Completed low sum bits propagate down the pipe.
  - The not-yet-used high operand bits are skewed forward in registers.
  - Per-stage registers: valid bit, partial sum, carry, remaining A/B' slices, and the MSB carry-in (needed for ovf).
- Flags are computed combinationally from the final stage register:
  - cout = carry out of the top group.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|sum.
  - neg = sum[WIDTH-1].
- Handshake:
  - adv = ~out_valid | out_ready.
  - in_ready = adv.
  - On adv, every stage register loads from its predecessor; stage 0 loads from the inputs with valid = in_valid.
  - With adv low, all stages hold, including bubbles. No bubble collapsing.
- Transfer in occurs when in_valid & in_ready. Transfer out occurs when out_valid & out_ready.
- Output sum/cout/ovf/zero/neg must be held stable while out_valid=1 and out_ready=0.

## Timing
- Reset (synchronous): all stage valid bits cleared; data registers cleared to 0.
  - Next cycle: out_valid=0, sum=0, cout=0, ovf=0, zero=1, neg=0, in_ready=1.
- Reset takes priority over any concurrent transfer. In-flight operations are discarded and not output.
- Latency: an operation accepted at rising edge E is presented (out_valid=1) after edge E+L-1, i.e. visible in the cycle following that edge. With L=1 it is visible the cycle after acceptance.
- Throughput: one operation per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 holds the whole pipe and drives in_ready=0 combinationally in the same cycle.
- Simultaneous out transfer and in transfer in the same cycle is legal and sustains full rate.
- in_valid=0 cycles insert bubbles that travel the pipe and appear as out_valid=0 cycles.
- in_ready depends combinationally on out_ready. No combinational path from a/b/op to in_ready.
- Wrap-around: arithmetic is modulo 2^WIDTH; the carry appears only on cout.

## Test plan
1. WIDTH=16, GPS=1 (L=4), out_ready=1: ADD a=0x1234, b=0x0FCD accepted at edge 0.
   - Response: out_valid only after edge 3; sum=0x2201, cout=0, ovf=0, zero=0.
2. SUB a=0x0005, b=0x0005.
   - Response: sum=0x0000, zero=1, cout=1 (no borrow), ovf=0.
   - Then SUB a=0x0000, b=0x0001: sum=0xFFFF, cout=0, neg=1.
3. ADD a=0x7FFF, b=0x0001: sum=0x8000, ovf=1, neg=1.
   - Then ADC a=0xFFFF, b=0x0000, cin=1: sum=0x0000, cout=1, zero=1.
4. Back-to-back stream of 8 random ops with in_valid=1 and out_ready toggling 1,0,0,1,...
   - Results match a reference model in order, with no loss or duplication.
   - in_ready equals adv every cycle; outputs are stable during stalls.
5. Assert reset for one cycle while 3 ops are in flight.
   - Response: next cycle out_valid=0, sum=0, zero=1, in_ready=1; none of the in-flight results ever appear.
6. Re-run scenarios 1-4 with WIDTH=32 at GPS=8 (L=1) and at GPS=2 (L=4).
   - Response: identical arithmetic results, latency L cycles.
